// File: rtl/conv3x3_sched.sv
// conv3x3_sched: raster-stream 3x3 window sequencer driving a filter3x3 datapath.
// Two line buffers supply the upper rows; results are realigned with window coordinates.
module conv3x3_sched #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int FILT_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [9*DATA_W-1:0]        w_data,
    output logic                       busy,
    output logic                       done,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [DATA_W-1:0]          pix_data,
    output logic                       filt_ena,
    output logic [9*DATA_W-1:0]        filt_in_matrix,
    output logic [9*DATA_W-1:0]        filt_filter_matrix,
    input  logic [2*DATA_W-1:0]        filt_out,
    output logic                       res_valid,
    output logic [2*DATA_W-1:0]        res_data,
    output logic [$clog2(IMG_H)-1:0]   res_row,
    output logic [$clog2(IMG_W)-1:0]   res_col
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = 3*DATA_W;
    localparam int KW = $clog2(FILT_LAT+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t state, state_nx;
    logic [XW-1:0] x, ena_col;
    logic [YW-1:0] y, ena_row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [CW-1:0] col_a, col_b, col_n;
    logic [FILT_LAT-1:0] dv;
    logic [FILT_LAT-1:0][YW-1:0] dr;
    logic [FILT_LAT-1:0][XW-1:0] dc;
    logic [KW-1:0] dcnt;
    logic acc, issue, x_last, last_pix;

    assign acc      = pix_valid && pix_ready;
    assign x_last   = x == XW'(IMG_W-1);
    assign last_pix = x_last && y == YW'(IMG_H-1);
    assign issue    = acc && x >= XW'(2) && y >= YW'(2);
    // Column entering the window: {row y-2, row y-1, row y} at column x
    assign col_n    = {lb1[x], lb0[x], pix_data};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
            S_RUN:   state_nx = acc && last_pix ? S_DRAIN : S_RUN;
            S_DRAIN: state_nx = dcnt == KW'(FILT_LAT-1) ? S_FIN : S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state != S_IDLE;
        pix_ready = state == S_RUN;
        done      = state == S_FIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x                  <= '0;
            y                  <= '0;
            col_a              <= '0;
            col_b              <= '0;
            filt_ena           <= 1'b0;
            filt_in_matrix     <= '0;
            filt_filter_matrix <= '0;
            ena_row            <= '0;
            ena_col            <= '0;
            dv                 <= '0;
            dr                 <= '0;
            dc                 <= '0;
            dcnt               <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else begin
            filt_ena <= issue;
            dcnt     <= state == S_DRAIN ? dcnt + 1'b1 : '0;
            dv[0]    <= filt_ena;
            dr[0]    <= ena_row;
            dc[0]    <= ena_col;
            for (int i = 1; i < FILT_LAT; i++) begin
                dv[i] <= dv[i-1];
                dr[i] <= dr[i-1];
                dc[i] <= dc[i-1];
            end
            if (state == S_IDLE && start) begin
                filt_filter_matrix <= w_data;
                x                  <= '0;
                y                  <= '0;
            end
            if (acc) begin
                lb0[x] <= pix_data;
                lb1[x] <= lb0[x];
                // Clearing history at column 0 keeps windows inside one row
                col_a  <= x == '0 ? '0 : col_b;
                col_b  <= col_n;
                x      <= x_last ? '0 : x + 1'b1;
                y      <= x_last ? y + 1'b1 : y;
                if (issue) begin
                    filt_in_matrix <= {col_a[CW-1 -: DATA_W], col_b[CW-1 -: DATA_W], col_n[CW-1 -: DATA_W],
                                       col_a[2*DATA_W-1 -: DATA_W], col_b[2*DATA_W-1 -: DATA_W], col_n[2*DATA_W-1 -: DATA_W],
                                       col_a[DATA_W-1:0], col_b[DATA_W-1:0], col_n[DATA_W-1:0]};
                    ena_row        <= y - YW'(2);
                    ena_col        <= x - XW'(2);
                end
            end
        end
    end

    assign res_valid = dv[FILT_LAT-1];
    assign res_row   = dr[FILT_LAT-1];
    assign res_col   = dc[FILT_LAT-1];
    assign res_data  = res_valid ? filt_out : '0;
endmodule

// File: tb/tb_conv3x3_sched.sv
// tb_conv3x3_sched: directed frames on a 4x4 image with a behavioural filter3x3 stand-in.
module tb_conv3x3_sched;
    localparam int DW = 8, W = 4, H = 4, L = 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_valid = 1'b0;
    logic [9*DW-1:0] w_data = '0;
    logic [DW-1:0] pix_data = '0;
    logic busy, done, pix_ready, filt_ena, res_valid;
    logic [9*DW-1:0] filt_in_matrix, filt_filter_matrix;
    logic [2*DW-1:0] filt_out, res_data;
    logic [1:0] res_row, res_col;

    conv3x3_sched #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .FILT_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .w_data(w_data), .busy(busy), .done(done),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .filt_ena(filt_ena), .filt_in_matrix(filt_in_matrix), .filt_filter_matrix(filt_filter_matrix),
        .filt_out(filt_out), .res_valid(res_valid), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mac(input logic [71:0] a, input logic [71:0] b);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s += 16'(a[i*8 +: 8]) * 16'(b[i*8 +: 8]);
        return s;
    endfunction

    // One-cycle-latency filter3x3 stand-in
    always @(posedge clk) begin
        if (rst) filt_out <= '0;
        else if (filt_ena) filt_out <= mac(filt_in_matrix, filt_filter_matrix);
    end

    int checks = 0, fails = 0, cyc = 0;
    int res_n = 0, ena_n = 0, done_n = 0, done_cyc = 0, wt_bad = 0;
    int ena_cyc [64];
    logic [15:0] rd [64];
    logic [1:0] rr [64], rc [64];
    logic [71:0] w_exp = '0;
    int r0, e0, d0, acc11, acc_last;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (res_valid && res_n < 64) begin
            rd[res_n] = res_data;
            rr[res_n] = res_row;
            rc[res_n] = res_col;
            res_n++;
        end
        if (filt_ena && ena_n < 64) begin
            ena_cyc[ena_n] = cyc;
            ena_n++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && filt_filter_matrix !== w_exp) wt_bad++;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_frame(input logic [71:0] w);
        step();
        start = 1'b1;
        w_data = w;
        w_exp = w;
        r0 = res_n;
        e0 = ena_n;
        d0 = done_n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit seq, input int gap, input int poke, input logic [71:0] pw);
        for (int i = 0; i < n; i++) begin
            pix_data = seq ? 8'(i + 1) : 8'd1;
            pix_valid = 1'b1;
            if (i == poke) begin
                start = 1'b1;
                w_data = pw;
            end
            check($sformatf("ready_p%0d", i), pix_ready, 1);
            if (i == 10) acc11 = cyc;
            acc_last = cyc;
            step();
            start = 1'b0;
            pix_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic end_frame(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                             input logic [15:0] x2, input logic [15:0] x3);
        logic [15:0] ex [4];
        ex = '{x0, x1, x2, x3};
        for (int t = 0; t < 40 && done_n == d0; t++) step();
        check({tag, "_done"}, done_n - d0, 1);
        check({tag, "_done_cyc"}, done_cyc, acc_last + 2);
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_nres"}, res_n - r0, 4);
        check({tag, "_nena"}, ena_n - e0, 4);
        check({tag, "_first_ena"}, ena_cyc[e0], acc11 + 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_data%0d", tag, k), rd[r0+k], ex[k]);
            check($sformatf("%s_row%0d", tag, k), rr[r0+k], k / 2);
            check($sformatf("%s_col%0d", tag, k), rc[r0+k], k % 2);
        end
        check({tag, "_wstable"}, wt_bad, 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, pix_ready, 0);
        check({tag, "_ena"}, filt_ena, 0);
        check({tag, "_rvalid"}, res_valid, 0);
        check({tag, "_rdata"}, res_data, 0);
        check({tag, "_rowcol"}, {res_row, res_col}, 0);
        check({tag, "_inmat"}, filt_in_matrix, 0);
        check({tag, "_wmat"}, filt_filter_matrix, 0);
    endtask

    initial begin
        logic [71:0] ones, center;
        ones = {9{8'd1}};
        center = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        step();
        step();
        check_cleared("reset");
        rst = 1'b0;
        step();

        begin_frame(ones);
        feed(16, 1'b0, 0, -1, '0);
        end_frame("flat", 9, 9, 9, 9);

        begin_frame(ones);
        feed(16, 1'b1, 0, -1, '0);
        end_frame("ramp", 54, 63, 90, 99);

        begin_frame(center);
        feed(16, 1'b1, 0, -1, '0);
        end_frame("center", 6, 7, 10, 11);
        check("center_wmat", filt_filter_matrix, center);

        begin_frame(ones);
        feed(16, 1'b1, 3, -1, '0);
        end_frame("stall", 54, 63, 90, 99);

        begin_frame(ones);
        feed(16, 1'b1, 0, 5, center);
        end_frame("busy_start", 54, 63, 90, 99);
        check("busy_start_wmat", filt_filter_matrix, ones);

        begin_frame(center);
        feed(16, 1'b1, 0, -1, '0);
        end_frame("reload", 6, 7, 10, 11);

        begin_frame(ones);
        feed(7, 1'b1, 0, -1, '0);
        rst = 1'b1;
        step();
        check_cleared("abort");
        rst = 1'b0;
        d0 = done_n;
        repeat (6) step();
        check("abort_nodone", done_n - d0, 0);
        check("abort_idle", busy, 0);

        begin_frame(ones);
        feed(16, 1'b1, 0, -1, '0);
        end_frame("fresh", 54, 63, 90, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
